// File: rtl/huff_decoder.sv
// huff_decoder: captures a Huffman code map from the encoder's phase-flagged
// bus, then decodes an MSB-first serial bitstream into symbols at one bit/cycle.
module huff_decoder #(
  parameter int bit_width = 7,
  parameter int max_syms  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*bit_width+2:0] map_in,
  input  logic                   data_recv,
  input  logic                   code_map_recv,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [bit_width:0]     sym_out,
  output logic                   sym_valid,
  output logic                   map_ready,
  output logic [7:0]             num_syms,
  output logic                   err
);
  localparam int CW = 2 * bit_width + 3;
  localparam int SW = bit_width + 1;
  localparam int AW = (max_syms > 1) ? $clog2(max_syms) : 1;
  localparam int IW = $clog2(max_syms + 1);
  localparam int LW = $clog2(CW + 1);

  localparam logic [1:0] PH_CODE = 2'b01;
  localparam logic [1:0] PH_LEN  = 2'b10;
  localparam logic [1:0] PH_SYM  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_LEN, LOAD_CODE, LOAD_SYM, DECODE} state_t;
  state_t state_reg, state_next;

  logic [7:0]    len_mem  [max_syms];
  logic [CW-1:0] code_mem [max_syms];
  logic [SW-1:0] sym_mem  [max_syms];

  logic [IW-1:0] idx_reg, idx_next;
  logic [IW-1:0] n_reg, n_next;
  logic [CW-2:0] acc_reg;
  logic [LW-1:0] acc_len_reg;

  logic [1:0]    phase;
  logic [AW-1:0] wr_addr;
  logic start_map, len_we, code_we, sym_we, len_over, abort, load_done, take_bit;

  assign phase     = {data_recv, code_map_recv};
  assign bit_ready = (state_reg == DECODE);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    n_next     = n_reg;
    wr_addr    = AW'(idx_reg);
    start_map  = 1'b0;
    len_we     = 1'b0;
    code_we    = 1'b0;
    sym_we     = 1'b0;
    len_over   = 1'b0;
    abort      = 1'b0;
    load_done  = 1'b0;
    take_bit   = 1'b0;
    case (state_reg)
      IDLE, DECODE: begin
        // A new length word always wins over any bit offered in DECODE.
        if (phase == PH_LEN) begin
          start_map  = 1'b1;
          len_we     = 1'b1;
          wr_addr    = '0;
          idx_next   = IW'(1);
          state_next = LOAD_LEN;
        end else if (state_reg == DECODE) begin
          take_bit = bit_valid;
        end
      end
      LOAD_LEN: begin
        case (phase)
          PH_LEN: begin
            if (idx_reg < IW'(max_syms)) begin
              len_we   = 1'b1;
              idx_next = idx_reg + IW'(1);
            end else begin
              len_over = 1'b1;
            end
          end
          PH_CODE: begin
            n_next     = idx_reg;
            code_we    = 1'b1;
            wr_addr    = '0;
            idx_next   = IW'(1);
            state_next = LOAD_CODE;
          end
          default: abort = 1'b1;
        endcase
      end
      LOAD_CODE: begin
        case (phase)
          PH_CODE: begin
            if (idx_reg < IW'(max_syms)) begin
              code_we  = 1'b1;
              idx_next = idx_reg + IW'(1);
            end
          end
          PH_SYM: begin
            sym_we     = 1'b1;
            wr_addr    = '0;
            idx_next   = IW'(1);
            load_done  = (n_reg == IW'(1));
            state_next = load_done ? DECODE : LOAD_SYM;
          end
          default: abort = 1'b1;
        endcase
      end
      LOAD_SYM: begin
        if (phase == PH_SYM) begin
          sym_we    = 1'b1;
          idx_next  = idx_reg + IW'(1);
          load_done = (idx_next == n_reg);
          if (load_done) state_next = DECODE;
        end else begin
          abort = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Table storage carries no reset; its contents are only trusted once map_ready.
  always_ff @(posedge clock) begin
    if (len_we)  len_mem[wr_addr]  <= map_in[7:0];
    if (code_we) code_mem[wr_addr] <= map_in;
    if (sym_we)  sym_mem[wr_addr]  <= map_in[bit_width:0];
  end

  logic [CW-1:0]       cand, cand_mask;
  logic [LW-1:0]       cand_len;
  logic [max_syms-1:0] hit;
  logic [SW-1:0]       hit_sym, dec_sym;
  logic                dec_hit;

  assign cand      = {acc_reg, bit_in};
  assign cand_len  = acc_len_reg + LW'(1);
  assign cand_mask = ~({CW{1'b1}} << cand_len);

  for (genvar gi = 0; gi < max_syms; gi++) begin : g_match
    assign hit[gi] = (IW'(gi) < n_reg) && (len_mem[gi] != 8'd0) &&
                     (len_mem[gi] == 8'(cand_len)) &&
                     (((code_mem[gi] ^ cand) & cand_mask) == '0);
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_sym = '0;
    for (int i = max_syms - 1; i >= 0; i--) begin
      if (hit[i]) hit_sym = sym_mem[i];
    end
  end

  assign dec_hit = (n_reg == IW'(1)) || (|hit);
  assign dec_sym = (n_reg == IW'(1)) ? sym_mem[0] : hit_sym;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      n_reg       <= '0;
      acc_reg     <= '0;
      acc_len_reg <= '0;
      sym_out     <= '0;
      sym_valid   <= 1'b0;
      map_ready   <= 1'b0;
      num_syms    <= 8'd0;
      err         <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      n_reg     <= n_next;
      sym_valid <= 1'b0;
      if (start_map) begin
        err         <= 1'b0;
        map_ready   <= 1'b0;
        acc_reg     <= '0;
        acc_len_reg <= '0;
      end
      if (len_over) err <= 1'b1;
      if (abort) begin
        err       <= 1'b1;
        map_ready <= 1'b0;
      end
      if (load_done) begin
        map_ready <= 1'b1;
        num_syms  <= 8'(n_reg);
      end
      if (take_bit) begin
        if (dec_hit) begin
          sym_out     <= dec_sym;
          sym_valid   <= 1'b1;
          acc_reg     <= '0;
          acc_len_reg <= '0;
        end else if (cand_len == LW'(CW)) begin
          err         <= 1'b1;
          acc_reg     <= '0;
          acc_len_reg <= '0;
        end else begin
          acc_reg     <= cand[CW-2:0];
          acc_len_reg <= cand_len;
        end
      end
    end
  end
endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder: directed and randomized map loads and bitstreams checked
// cycle by cycle against a behavioural table-lookup decoder model.
module tb_huff_decoder;
  localparam int BW   = 7;
  localparam int CW   = 2 * BW + 3;
  localparam int MAXS = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] map_in;
  logic          data_recv, code_map_recv, bit_in, bit_valid;
  logic          bit_ready, sym_valid, map_ready, err;
  logic [BW:0]   sym_out;
  logic [7:0]    num_syms;

  huff_decoder #(.bit_width(BW), .max_syms(MAXS)) dut (
    .clock(clock), .reset(reset), .map_in(map_in), .data_recv(data_recv),
    .code_map_recv(code_map_recv), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sym_out(sym_out), .sym_valid(sym_valid),
    .map_ready(map_ready), .num_syms(num_syms), .err(err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Table being transmitted, and the model's view of the active table.
  int t_len[MAXS], t_code[MAXS], t_sym[MAXS];
  int m_len[MAXS], m_code[MAXS], m_sym[MAXS], m_n;
  bit m_decode, m_err, m_map_ready;
  int m_sym_out, m_num, m_acc_len;
  longint m_acc;
  int got_q[$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_valid);
    chk_val({tag, ".sym_valid"}, 32'(sym_valid), 32'(exp_valid));
    chk_val({tag, ".sym_out"},   32'(sym_out),   m_sym_out);
    chk_val({tag, ".err"},       32'(err),       32'(m_err));
    chk_val({tag, ".map_ready"}, 32'(map_ready), 32'(m_map_ready));
    chk_val({tag, ".bit_ready"}, 32'(bit_ready), 32'(m_decode));
    chk_val({tag, ".num_syms"},  32'(num_syms),  m_num);
  endtask

  // Reference decode: grow the pending code, look it up by (length, value).
  function automatic bit model_bit(input bit b);
    longint cur;
    int cur_len, hit;
    cur = (m_acc << 1) | longint'(b);
    cur_len = m_acc_len + 1;
    hit = -1;
    if (m_n == 1) hit = 0;
    else
      for (int i = 0; i < m_n; i++)
        if (hit < 0 && m_len[i] != 0 && m_len[i] == cur_len &&
            longint'(m_code[i] % (1 << cur_len)) == cur) hit = i;
    if (hit >= 0) begin
      m_sym_out = m_sym[hit];
      m_acc = 0;
      m_acc_len = 0;
      return 1'b1;
    end
    if (cur_len == CW) begin
      m_err = 1'b1;
      m_acc = 0;
      m_acc_len = 0;
    end else begin
      m_acc = cur;
      m_acc_len = cur_len;
    end
    return 1'b0;
  endfunction

  task automatic send_bit(input bit b, input bit v, input string tag);
    bit ev;
    @(negedge clock);
    {data_recv, code_map_recv} = 2'b00;
    map_in = '0;
    bit_in = b;
    bit_valid = v;
    @(posedge clock);
    #1;
    ev = 1'b0;
    if (v && m_decode) ev = model_bit(b);
    if (sym_valid) got_q.push_back(int'(sym_out));
    check_outputs(tag, ev);
  endtask

  task automatic drive_word(input logic [1:0] ph, input int val);
    @(negedge clock);
    {data_recv, code_map_recv} = ph;
    map_in = CW'(val);
    bit_in = 1'($urandom_range(0, 1));
    bit_valid = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
  endtask

  task automatic load_map(input int n, input string tag);
    m_err = 1'b0;
    m_map_ready = 1'b0;
    m_decode = 1'b0;
    m_acc = 0;
    m_acc_len = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < n; i++) begin
        case (p)
          0:       drive_word(2'b10, t_len[i]);
          1:       drive_word(2'b01, t_code[i]);
          default: drive_word(2'b11, t_sym[i]);
        endcase
        if (p == 2 && i == n - 1) begin
          m_map_ready = 1'b1;
          m_decode = 1'b1;
          m_num = n;
          m_n = n;
          m_len = t_len;
          m_code = t_code;
          m_sym = t_sym;
        end
        check_outputs(tag, 1'b0);
      end
    end
  endtask

  task automatic set_abc(input int sa, input int sb, input int sc);
    t_len[0] = 1; t_code[0] = 0; t_sym[0] = sa;
    t_len[1] = 2; t_code[1] = 2; t_sym[1] = sb;
    t_len[2] = 2; t_code[2] = 3; t_sym[2] = sc;
  endtask

  task automatic check_syms(input string tag, input int e0, input int e1, input int e2, input int cnt);
    int exp_a[3];
    exp_a = '{e0, e1, e2};
    chk_val({tag, ".count"}, got_q.size(), cnt);
    for (int k = 0; k < cnt && k < 3; k++)
      chk_val({tag, ".sym"}, (k < got_q.size()) ? got_q[k] : -1, exp_a[k]);
  endtask

  int n, e;
  bit bits5[5];

  initial begin
    reset = 1'b1;
    map_in = '0;
    data_recv = 1'b0;
    code_map_recv = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    m_decode = 0; m_err = 0; m_map_ready = 0;
    m_sym_out = 0; m_num = 0; m_n = 0; m_acc = 0; m_acc_len = 0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Three-entry map A/B/C decoded back to back.
    set_abc(8'h41, 8'h42, 8'h43);
    load_map(3, "abc_load");
    chk_val("abc.num_syms", 32'(num_syms), 3);
    bits5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    got_q.delete();
    foreach (bits5[k]) send_bit(bits5[k], 1'b1, "abc_bit");
    check_syms("abc", 8'h41, 8'h42, 8'h43, 3);

    // Same map with bit_valid gapped.
    load_map(3, "gap_load");
    got_q.delete();
    foreach (bits5[k]) begin
      send_bit(1'($urandom_range(0, 1)), 1'b0, "gap_idle");
      send_bit(bits5[k], 1'b1, "gap_bit");
    end
    check_syms("gap", 8'h41, 8'h42, 8'h43, 3);

    // Single zero-length entry: every valid bit emits it.
    t_len[0] = 0; t_code[0] = 0; t_sym[0] = 8'h7F;
    load_map(1, "one_load");
    got_q.delete();
    repeat (3) send_bit(1'($urandom_range(0, 1)), 1'b1, "one_bit");
    check_syms("one", 8'h7F, 8'h7F, 8'h7F, 3);

    // Overflow: only code '1' can match, so 17 zeros trip err.
    t_len[0] = 1; t_code[0] = 1; t_sym[0] = 8'h55;
    t_len[1] = 0; t_code[1] = 0; t_sym[1] = 8'h66;
    load_map(2, "ovf_load");
    got_q.delete();
    repeat (16) send_bit(1'b0, 1'b1, "ovf_zero");
    chk_val("ovf.err_before", 32'(err), 0);
    send_bit(1'b0, 1'b1, "ovf_zero17");
    chk_val("ovf.err_after", 32'(err), 1);
    chk_val("ovf.no_pulse", got_q.size(), 0);
    send_bit(1'b1, 1'b1, "ovf_one");
    check_syms("ovf_recover", 8'h55, 0, 0, 1);

    // Reload in the middle of a partial code; err must clear.
    send_bit(1'b0, 1'b1, "mid_partial");
    send_bit(1'b0, 1'b1, "mid_partial");
    set_abc(8'h11, 8'h22, 8'h33);
    load_map(3, "mid_load");
    chk_val("mid.err_cleared", 32'(err), 0);
    got_q.delete();
    send_bit(1'b1, 1'b1, "mid_bit");
    send_bit(1'b1, 1'b1, "mid_bit");
    send_bit(1'b0, 1'b1, "mid_bit");
    check_syms("mid", 8'h33, 8'h11, 0, 2);

    // Protocol error: idle pattern during length loading.
    drive_word(2'b10, 1);
    m_err = 0; m_map_ready = 0; m_decode = 0;
    check_outputs("proto_len", 1'b0);
    drive_word(2'b00, 0);
    m_err = 1;
    check_outputs("proto_idle", 1'b0);
    send_bit(1'b0, 1'b1, "proto_drop");

    // Asynchronous reset while loading codes.
    set_abc(8'h10, 8'h20, 8'h30);
    drive_word(2'b10, 1);
    drive_word(2'b10, 2);
    drive_word(2'b10, 2);
    drive_word(2'b01, 0);
    reset = 1'b1;
    #1;
    m_err = 0; m_map_ready = 0; m_decode = 0; m_sym_out = 0; m_num = 0;
    check_outputs("async_reset", 1'b0);
    @(negedge clock);
    {data_recv, code_map_recv} = 2'b00;
    bit_valid = 1'b0;
    reset = 1'b0;
    load_map(3, "post_reset_load");
    got_q.delete();
    send_bit(1'b1, 1'b1, "post_reset_bit");
    send_bit(1'b1, 1'b1, "post_reset_bit");
    send_bit(1'b1, 1'b0, "post_reset_bit");
    send_bit(1'b1, 1'b1, "post_reset_bit");
    send_bit(1'b0, 1'b1, "post_reset_bit");
    send_bit(1'b0, 1'b1, "post_reset_bit");
    check_syms("post_reset", 8'h30, 8'h20, 8'h10, 3);

    // Randomized maps and streams, reloading straight out of DECODE.
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        t_len[i]  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
        t_code[i] = $urandom_range(0, (1 << t_len[i]) - 1);
        t_sym[i]  = $urandom_range(0, 255);
      end
      load_map(n, "rnd_load");
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_bit");
        end else begin
          e = $urandom_range(0, n - 1);
          for (int j = t_len[e] - 1; j >= 0; j--)
            send_bit(1'((t_code[e] >> j) & 1), $urandom_range(0, 3) != 0, "rnd_code");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
